// File: rtl/scroll_word_disp.sv
// ---------------------------------------------------------------------------
// scroll_word_disp
//
// Drives NUM_DIGITS active-low seven-segment digits from a MSG_LEN-character
// message of 5-bit character codes. Four display modes: static, scroll-left
// with wrap-around, blink, and a forced-dash override on en. An internal
// prescaler produces the scroll/blink tick.
//
// Ports:
//   clk   in   1              system clock
//   rst   in   1              asynchronous active-high reset
//   en    in   1              1 = every digit shows a dash (highest priority)
//   mode  in   2              00 static, 01 scroll-left, 10 blink, 11 static
//   msg   in   MSG_LEN*5      char i at [5i+4:5i], char 0 is leftmost
//   seg   out  NUM_DIGITS*7   digit k (k=0 leftmost) at
//                             [7(NUM_DIGITS-k)-1 : 7(NUM_DIGITS-k-1)],
//                             bit order {g,f,e,d,c,b,a}, active-low
//   pos   out  clog2(MSG_LEN) current window start index
//   tick  out  1              one-cycle pulse at each prescaler wrap
// ---------------------------------------------------------------------------
module scroll_word_disp #(
  parameter int NUM_DIGITS = 5,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 25000000,
  localparam int POS_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [MSG_LEN*5-1:0]    msg,
  output logic [NUM_DIGITS*7-1:0] seg,
  output logic [POS_W-1:0]        pos,
  output logic                    tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = POS_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST    = POS_W'(MSG_LEN - 1);
  localparam logic [IDX_W-1:0] MSG_LEN_IDX = IDX_W'(MSG_LEN);

  localparam logic [1:0] MODE_SCROLL = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // -------------------------------------------------------------------------
  // Character code to segment pattern ({g,f,e,d,c,b,a}, active-low)
  // -------------------------------------------------------------------------
  function automatic logic [6:0] decode_char(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:  s = 7'b1000000;
      5'd1:  s = 7'b1111001;
      5'd2:  s = 7'b0100100;
      5'd3:  s = 7'b0110000;
      5'd4:  s = 7'b0011001;
      5'd5:  s = 7'b0010010;
      5'd6:  s = 7'b0000010;
      5'd7:  s = 7'b1111000;
      5'd8:  s = 7'b0000000;
      5'd9:  s = 7'b0010000;
      5'd10: s = 7'b0001000; // A
      5'd11: s = 7'b0000011; // b
      5'd12: s = 7'b1000110; // C
      5'd13: s = 7'b0100001; // d
      5'd14: s = 7'b0000110; // E
      5'd15: s = 7'b0001110; // F
      5'd16: s = 7'b0001001; // H
      5'd17: s = 7'b0000110; // E
      5'd18: s = 7'b1000111; // L
      5'd19: s = 7'b0001100; // P
      5'd20: s = 7'b1000001; // U
      5'd21: s = SEG_DASH;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Prescaler: counts 0..TICK_DIV-1; tick is registered so it is high in the
  // cycle after the terminal count. Free-running regardless of mode or en.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic             tick_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (cnt_reg == CNT_LAST);
      cnt_reg  <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Window position and blink phase. en freezes both (ticks are dropped);
  // otherwise the mode seen in the current cycle decides, so a mode change
  // coinciding with a tick follows the new mode.
  // -------------------------------------------------------------------------
  logic [POS_W-1:0] pos_reg;
  logic             phase_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (!en) begin
      case (mode)
        MODE_SCROLL: begin
          phase_reg <= 1'b0;
          if (tick_reg)
            pos_reg <= (pos_reg == POS_LAST) ? '0 : pos_reg + POS_W'(1);
        end
        MODE_BLINK: begin
          pos_reg <= '0;
          if (tick_reg)
            phase_reg <= ~phase_reg;
        end
        default: begin
          pos_reg   <= '0;
          phase_reg <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Message unpack and per-digit window selection with wrap-around.
  // pos < MSG_LEN and k < NUM_DIGITS <= MSG_LEN, so pos+k < 2*MSG_LEN and a
  // single conditional subtract gives (pos+k) mod MSG_LEN.
  // -------------------------------------------------------------------------
  logic [4:0] chars [MSG_LEN];

  for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_unpack
    assign chars[gi] = msg[5*gi +: 5];
  end

  logic [NUM_DIGITS*7-1:0] seg_next;
  logic                    blank_all;

  // Blink off-phase only applies while the blink mode is actually selected.
  assign blank_all = (mode == MODE_BLINK) && phase_reg;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [IDX_W-1:0] sum;
    logic [IDX_W-1:0] idx;
    logic [4:0]       code;
    logic [6:0]       pattern;

    assign sum = {1'b0, pos_reg} + IDX_W'(gi);

    always_comb begin
      idx = sum;
      if (sum >= MSG_LEN_IDX)
        idx = sum - MSG_LEN_IDX;
    end

    assign code = chars[idx[POS_W-1:0]];

    always_comb begin
      pattern = decode_char(code);
      if (en)
        pattern = SEG_DASH;
      else if (blank_all)
        pattern = SEG_BLANK;
    end

    // Digit 0 occupies the most significant 7 bits.
    assign seg_next[7*(NUM_DIGITS-gi)-1 -: 7] = pattern;
  end

  // -------------------------------------------------------------------------
  // Registered segment output: one clock from any input or pos change.
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS*7-1:0] seg_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      seg_reg <= '1;
    else
      seg_reg <= seg_next;
  end

  assign seg  = seg_reg;
  assign pos  = pos_reg;
  assign tick = tick_reg;

endmodule

// File: tb/tb_scroll_word_disp.sv
// Directed testbench for scroll_word_disp (NUM_DIGITS=5, MSG_LEN=8, TICK_DIV=4).
module tb_scroll_word_disp;

  localparam int ND = 5;
  localparam int ML = 8;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [39:0] msg;
  logic [34:0] seg;
  logic [2:0]  pos;
  logic        tick;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] S_H = 7'b0001001;
  localparam logic [6:0] S_E = 7'b0000110;
  localparam logic [6:0] S_L = 7'b1000111;
  localparam logic [6:0] S_O = 7'b1000000;
  localparam logic [6:0] S_B = 7'b1111111;
  localparam logic [6:0] S_D = 7'b0111111;

  // H,E,L,L,O,blank,blank,blank with char 0 in the low bits
  localparam logic [39:0] MSG_HELLO = {5'd31, 5'd31, 5'd31, 5'd0, 5'd18, 5'd18, 5'd17, 5'd16};
  localparam logic [34:0] SEG_HELLO = {S_H, S_E, S_L, S_L, S_O};
  localparam logic [34:0] SEG_DASHES = {S_D, S_D, S_D, S_D, S_D};

  logic [6:0] dec_tab [32] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b0001001, 7'b0000110,
    7'b1000111, 7'b0001100, 7'b1000001, 7'b0111111, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111
  };

  scroll_word_disp #(
    .NUM_DIGITS(ND),
    .MSG_LEN   (ML),
    .TICK_DIV  (TD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .msg (msg),
    .seg (seg),
    .pos (pos),
    .tick(tick)
  );

  always #5 clk = ~clk;

  // Bounded waits; an expired bound is reported as a failed comparison.
  task automatic wait_tick(input string name);
    int n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tick !== 1'b1) begin
      bad++;
      $display("FAIL %s_tick_wait: tick=%b want 1 within 20 cycles", name, tick);
    end
  endtask

  task automatic wait_pos(input string name, input logic [2:0] p);
    int n = 0;
    while (pos !== p && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (pos !== p) begin
      bad++;
      $display("FAIL %s_pos_wait: pos=%0d want %0d within 60 cycles", name, pos, p);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; mode = 2'b00; msg = MSG_HELLO;
    #2;
    total++;
    if (seg !== '1) begin bad++; $display("FAIL reset_seg: seg=%h want %h", seg, {35{1'b1}}); end
    total++;
    if (pos !== 3'd0) begin bad++; $display("FAIL reset_pos: pos=%0d want 0", pos); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: tick=%b want 0", tick); end
    @(negedge clk); @(negedge clk);
    total++;
    if (seg !== '1) begin bad++; $display("FAIL reset_hold_seg: seg=%h want all ones", seg); end
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      total++;
      if (tick !== (c == TD)) begin
        bad++;
        $display("FAIL reset_tick_cycle%0d: tick=%b want %b", c, tick, (c == TD));
      end
    end
    $display("reset: done, first tick after %0d cycles", TD);
  endtask

  task automatic test_static;
    mode = 2'b00;
    for (int i = 0; i < ML; i++) msg[5*i +: 5] = 5'd21;
    @(negedge clk);
    total++;
    if (seg !== SEG_DASHES) begin bad++; $display("FAIL static_dash_chars: seg=%h want %h", seg, SEG_DASHES); end
    msg = MSG_HELLO;
    @(negedge clk);
    total++;
    if (seg !== SEG_HELLO) begin bad++; $display("FAIL static_hello: seg=%h want %h", seg, SEG_HELLO); end
    total++;
    if (pos !== 3'd0) begin bad++; $display("FAIL static_pos: pos=%0d want 0", pos); end
    $display("static: seg=%h", seg);
  endtask

  task automatic test_scroll;
    logic [2:0] exp_pos;
    exp_pos = 3'd0;
    mode = 2'b01;
    for (int step = 1; step <= ML; step++) begin
      wait_tick("scroll");
      @(negedge clk);
      exp_pos = (exp_pos == 3'd7) ? 3'd0 : exp_pos + 3'd1;
      total++;
      if (pos !== exp_pos) begin bad++; $display("FAIL scroll_pos_step%0d: pos=%0d want %0d", step, pos, exp_pos); end
      if (exp_pos == 3'd5) begin
        @(negedge clk);
        total++;
        if (seg !== {S_B, S_B, S_B, S_H, S_E}) begin
          bad++; $display("FAIL scroll_win_pos5: seg=%h want %h", seg, {S_B, S_B, S_B, S_H, S_E});
        end
      end
      if (exp_pos == 3'd7) begin
        @(negedge clk);
        total++;
        if (seg !== {S_B, S_H, S_E, S_L, S_L}) begin
          bad++; $display("FAIL scroll_win_pos7: seg=%h want %h", seg, {S_B, S_H, S_E, S_L, S_L});
        end
      end
      $display("scroll: step %0d pos=%0d", step, pos);
    end
  endtask

  task automatic test_override;
    wait_pos("override", 3'd2);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (seg !== SEG_DASHES) begin bad++; $display("FAIL override_seg_c%0d: seg=%h want %h", i, seg, SEG_DASHES); end
      total++;
      if (pos !== 3'd2) begin bad++; $display("FAIL override_pos_c%0d: pos=%0d want 2", i, pos); end
    end
    en = 1'b0;
    @(negedge clk);
    total++;
    if (seg !== {S_L, S_L, S_O, S_B, S_B}) begin
      bad++; $display("FAIL override_resume: seg=%h want %h", seg, {S_L, S_L, S_O, S_B, S_B});
    end
    mode = 2'b00;
    $display("override: resumed seg=%h", seg);
  endtask

  task automatic test_blink;
    mode = 2'b00;
    @(negedge clk);
    mode = 2'b10;
    wait_tick("blink1"); @(negedge clk); @(negedge clk);
    total++;
    if (seg !== '1) begin bad++; $display("FAIL blink_off1: seg=%h want all ones", seg); end
    total++;
    if (pos !== 3'd0) begin bad++; $display("FAIL blink_pos: pos=%0d want 0", pos); end
    wait_tick("blink2"); @(negedge clk); @(negedge clk);
    total++;
    if (seg !== SEG_HELLO) begin bad++; $display("FAIL blink_on: seg=%h want %h", seg, SEG_HELLO); end
    wait_tick("blink3"); @(negedge clk); @(negedge clk);
    total++;
    if (seg !== '1) begin bad++; $display("FAIL blink_off2: seg=%h want all ones", seg); end
    mode = 2'b00;
    @(negedge clk);
    total++;
    if (seg !== SEG_HELLO) begin bad++; $display("FAIL blink_exit: seg=%h want %h", seg, SEG_HELLO); end
    $display("blink: exit seg=%h", seg);
  endtask

  task automatic test_mode_in_tick;
    mode = 2'b01;
    wait_pos("modetick", 3'd3);
    wait_tick("modetick");
    mode = 2'b00;
    @(negedge clk);
    total++;
    if (pos !== 3'd0) begin bad++; $display("FAIL mode_in_tick_pos: pos=%0d want 0", pos); end
    $display("mode_in_tick: pos=%0d", pos);
  endtask

  task automatic test_msg_change;
    mode = 2'b01;
    wait_pos("msgchg", 3'd1);
    for (int i = 0; i < ML; i++) msg[5*i +: 5] = 5'(i);
    @(negedge clk);
    total++;
    if (seg !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}) begin
      bad++;
      $display("FAIL msg_change_seg: seg=%h want %h", seg,
               {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010});
    end
    total++;
    if (pos !== 3'd1) begin bad++; $display("FAIL msg_change_pos: pos=%0d want 1", pos); end
    mode = 2'b00;
    $display("msg_change: seg=%h", seg);
  endtask

  task automatic test_decode;
    mode = 2'b00;
    en = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      msg[4:0] = 5'(c);
      @(negedge clk);
      total++;
      if (seg[34:28] !== dec_tab[c]) begin
        bad++; $display("FAIL decode_code%0d: digit0=%b want %b", c, seg[34:28], dec_tab[c]);
      end
    end
    $display("decode: swept 32 codes");
  endtask

  task automatic test_reset_mid;
    msg = MSG_HELLO;
    mode = 2'b01;
    wait_pos("rstmid", 3'd3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (seg !== '1) begin bad++; $display("FAIL reset_mid_seg: seg=%h want all ones", seg); end
    total++;
    if (pos !== 3'd0) begin bad++; $display("FAIL reset_mid_pos: pos=%0d want 0", pos); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL reset_mid_tick: tick=%b want 0", tick); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      total++;
      if (tick !== (c == TD)) begin
        bad++; $display("FAIL reset_mid_tick_cycle%0d: tick=%b want %b", c, tick, (c == TD));
      end
    end
    $display("reset_mid: done");
  endtask

  initial begin
    test_reset;
    test_static;
    test_scroll;
    test_override;
    test_blink;
    test_mode_in_tick;
    test_msg_change;
    test_decode;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scroll_word_disp.md
Name: scroll_word_disp

Overview:
Parametrised successor to the fixed five-digit word display for the DE2 seven-segment bank. Drives NUM_DIGITS active-low seven-segment digits from a MSG_LEN-character message supplied as 5-bit character codes. Supports four display modes: static, scroll-left with wrap, blink, and a forced-dash override. A built-in prescaler sets the scroll and blink rate. Sits between top-level switch logic and the HEX pins.

Parameters:
NUM_DIGITS, 5, number of seven-segment digits driven (>=1)
MSG_LEN, 8, characters in message (>= NUM_DIGITS)
TICK_DIV, 25000000, clk cycles per scroll/blink tick (>=2; 0.5 s at 50 MHz)

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock, asynchronous, active-high
en  input  1  override: 1 = all digits show dash, 0 = normal display
mode  input  2  00 static, 01 scroll-left, 10 blink, 11 static (reserved)
msg  input  MSG_LEN*5  char i at [5i+4:5i]; char 0 is the first/leftmost character
seg  output  NUM_DIGITS*7  digit k (k=0 leftmost) at [7(NUM_DIGITS-k)-1 : 7(NUM_DIGITS-k-1)]; bit order {g,f,e,d,c,b,a}; active-low
pos  output  clog2(MSG_LEN)  current window start index
tick  output  1  one-cycle pulse at each prescaler terminal count

Behaviour:
- Reset (asynchronous, any time including mid-scroll): seg all ones (blank), pos=0, prescaler=0, blink phase=0, tick=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 (registered) exactly in the cycle after count==TICK_DIV-1, i.e. one pulse every TICK_DIV cycles. Runs in all modes and under en.
- Char decode (5-bit code -> segments):
  - 0-9 digits (0=1000000, 1=1111001, ...); 10-15 A-F.
  - 16 H=0001001, 17 E=0000110, 18 L=1000111, 19 P=0001100, 20 U=1000001, 21 dash=0111111.
  - 22-31 blank=1111111.
- Window: digit k shows msg char (pos+k) mod MSG_LEN; wrap-around across the message end is required.
- mode 01 (scroll):
  - On tick, pos <= (pos==MSG_LEN-1) ? 0 : pos+1.
  - pos holds between ticks.
- mode 00/11 (static): pos forced to 0 on the next clock; no advance.
- mode 10 (blink):
  - pos forced to 0.
  - Blink phase toggles on each tick; phase 1 -> all digits blank, phase 0 -> window shown.
  - Phase is cleared to 0 whenever mode != 10.
- en=1 (highest priority):
  - Every digit = 0111111.
  - pos and blink phase frozen; a tick arriving while en=1 is ignored.
  - Normal display resumes at the held pos on the first cycle after en falls.
- Output latency: seg is registered. A change in en, mode, msg or pos is visible on seg exactly one clock later. No combinational path from inputs to seg.
- Simultaneous events:
  - A mode change in a tick cycle uses the new mode, e.g. switching to 00 clears pos and does not advance.
  - A msg change mid-scroll takes effect on the next clock with pos unchanged.

Test Plan:
- Reset: assert rst mid-scroll (pos=3) -> seg=all 1s immediately (asynchronous), pos=0; after release with TICK_DIV=4, first tick 4 cycles later.
- Static: msg=H,E,L,L,O,blank,blank,blank (16,17,18,18,0,31,31,31), mode=00, en=0 -> seg digits 0..4 = 0001001, 0000110, 1000111, 1000111, 1000000 one clock after inputs settle.
- Scroll wrap: same msg, mode=01, TICK_DIV=4 -> pos steps 0,1,...,7,0 every 4 cycles. At pos=5 digits = blank,blank,blank,H,E; at pos=7 digits = blank,H,E,L,L.
- Blink: mode=10 -> seg alternates HELLO / all 1s every 4 cycles; switching to 00 mid-blank shows HELLO the next cycle.
- Override: en=1 during scroll at pos=2 for 10 cycles -> all digits 0111111, pos stays 2; en=0 -> window from pos 2 (L,L,O,blank,blank).
- Decode sweep: cycle code 0..31 into char 0, mode=00 -> digit 0 matches the table; codes 22-31 give 1111111.
